// File: rtl/xor_parity_checker_if.sv
// Serial parity-link bundle: bit stream and count clear in, frame status and
// the reassembled word out.
interface xor_parity_checker_if #(
    parameter int DATA_BITS = 8,
    parameter int ECW       = 8
);
    logic                 EN;
    logic                 START;
    logic                 D;
    logic                 CLR_CNT;
    logic                 BUSY;
    logic                 DONE;
    logic                 ERR;
    logic                 ABORT;
    logic [ECW-1:0]       ERR_CNT;
    logic [DATA_BITS-1:0] Q;

    // Far end of the link: drives the bit stream, observes frame results.
    modport master (
        output EN, START, D, CLR_CNT,
        input  BUSY, DONE, ERR, ABORT, ERR_CNT, Q
    );

    // Checker side.
    modport slave (
        input  EN, START, D, CLR_CNT,
        output BUSY, DONE, ERR, ABORT, ERR_CNT, Q
    );
endinterface

// File: rtl/xor_parity_checker.sv
// Bit-serial parity frame receiver. Reassembles DATA_BITS LSB-first data bits,
// XORs them with the trailing parity bit and reports mismatches, restarts and
// a saturating count of errored frames.
module xor_parity_checker #(
    parameter int DATA_BITS = 8,
    parameter int ODD       = 0,
    parameter int ECW       = 8
) (
    input logic                CLK,
    input logic                RST,
    xor_parity_checker_if.slave bus
);
    localparam int             CW       = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0]  LAST_CNT = CW'(DATA_BITS - 1);
    localparam logic           ODD_BIT  = (ODD != 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PAR
    } state_t;

    state_t               state;
    logic [CW-1:0]        cnt;
    logic                 par_acc;
    logic [DATA_BITS-1:0] shift_q;
    logic                 frame_err;

    // Parity bit being accepted right now and it disagrees with the data.
    assign frame_err = bus.EN && !bus.START && (state == ST_PAR)
                       && (par_acc ^ bus.D ^ ODD_BIT);

    // Frame sequencer: shift register, bit counter, parity accumulator and
    // the registered status outputs.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge values of its neighbours.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            par_acc   <= 1'b0;
            shift_q   <= '0;
            bus.BUSY  <= 1'b0;
            bus.DONE  <= 1'b0;
            bus.ERR   <= 1'b0;
            bus.ABORT <= 1'b0;
            bus.Q     <= '0;
        end else begin
            // Pulses default low; only the producing branch raises them.
            bus.DONE  <= 1'b0;
            bus.ERR   <= 1'b0;
            bus.ABORT <= 1'b0;
            if (bus.EN) begin
                if (bus.START) begin
                    // New frame from any state; a frame in flight is dropped.
                    // Data enters at the MSB and shifts down, so after
                    // DATA_BITS bits the first one sits at bit 0.
                    bus.ABORT <= (state != ST_IDLE);
                    shift_q   <= {bus.D, {(DATA_BITS-1){1'b0}}};
                    par_acc   <= bus.D;
                    cnt       <= CW'(1);
                    state     <= ST_DATA;
                    bus.BUSY  <= 1'b1;
                end else begin
                    case (state)
                        ST_DATA: begin
                            shift_q <= {bus.D, shift_q[DATA_BITS-1:1]};
                            par_acc <= par_acc ^ bus.D;
                            cnt     <= cnt + 1'b1;
                            if (cnt == LAST_CNT) begin
                                state <= ST_PAR;
                            end
                        end
                        ST_PAR: begin
                            bus.DONE <= 1'b1;
                            bus.ERR  <= par_acc ^ bus.D ^ ODD_BIT;
                            bus.Q    <= shift_q;
                            state    <= ST_IDLE;
                            bus.BUSY <= 1'b0;
                            cnt      <= '0;
                            par_acc  <= 1'b0;
                        end
                        default: begin
                            // Idle bits without START are ignored.
                        end
                    endcase
                end
            end
        end
    end

    // Saturating errored-frame counter; clear wins over a coincident increment.
    always_ff @(posedge CLK) begin
        if (RST || bus.CLR_CNT) begin
            bus.ERR_CNT <= '0;
        end else if (frame_err && (bus.ERR_CNT != '1)) begin
            bus.ERR_CNT <= bus.ERR_CNT + 1'b1;
        end
    end
endmodule

// File: tb/tb_xor_parity_checker.sv
// Directed bench for xor_parity_checker: three instances share one stimulus
// stream (even/ECW=8, odd/ECW=8, even/ECW=2); each task checks the relevant one.
module tb_xor_parity_checker;
    logic CLK;
    logic RST;
    logic en;
    logic start;
    logic d;
    logic clr;

    int tests;
    int fails;
    int done_cnt;
    int abort_cnt;

    xor_parity_checker_if #(.DATA_BITS(8), .ECW(8)) if0 ();
    xor_parity_checker_if #(.DATA_BITS(8), .ECW(8)) if1 ();
    xor_parity_checker_if #(.DATA_BITS(8), .ECW(2)) if2 ();

    assign if0.EN = en;  assign if0.START = start;  assign if0.D = d;  assign if0.CLR_CNT = clr;
    assign if1.EN = en;  assign if1.START = start;  assign if1.D = d;  assign if1.CLR_CNT = clr;
    assign if2.EN = en;  assign if2.START = start;  assign if2.D = d;  assign if2.CLR_CNT = clr;

    xor_parity_checker #(.DATA_BITS(8), .ODD(0), .ECW(8)) u_even (.CLK(CLK), .RST(RST), .bus(if0));
    xor_parity_checker #(.DATA_BITS(8), .ODD(1), .ECW(8)) u_odd  (.CLK(CLK), .RST(RST), .bus(if1));
    xor_parity_checker #(.DATA_BITS(8), .ODD(0), .ECW(2)) u_sat  (.CLK(CLK), .RST(RST), .bus(if2));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Count pulses of the even instance, sampled on the falling edge.
    task automatic sample_mon();
        if (if0.DONE === 1'b1) done_cnt++;
        if (if0.ABORT === 1'b1) abort_cnt++;
    endtask

    // One bit slot: inputs change on the falling edge, DUT samples on the rise.
    task automatic step(input logic e, input logic s, input logic dd);
        @(negedge CLK);
        sample_mon();
        en = e; start = s; d = dd; clr = 1'b0;
    endtask

    task automatic idle_step();
        step(1'b0, 1'b0, 1'b0);
    endtask

    // Whole frame: 8 data bits LSB-first then parity, with gap idle cycles
    // between bits. clr_p raises CLR_CNT in the same slot as the parity bit.
    task automatic send_frame(input logic [7:0] w, input logic p, input int gap,
                              input logic clr_p);
        step(1'b1, 1'b1, w[0]);
        for (int i = 1; i < 8; i++) begin
            repeat (gap) idle_step();
            step(1'b1, 1'b0, w[i]);
        end
        repeat (gap) idle_step();
        step(1'b1, 1'b0, p);
        clr = clr_p;
    endtask

    task automatic reset_dut();
        @(negedge CLK);
        sample_mon();
        RST = 1'b1; en = 1'b0; start = 1'b0; d = 1'b0; clr = 1'b0;
        @(negedge CLK);
        sample_mon();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        reset_dut();
        tests++; if (if0.BUSY !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", if0.BUSY); end
        tests++; if (if0.DONE !== 1'b0 || if0.ERR !== 1'b0 || if0.ABORT !== 1'b0) begin
            fails++; $display("FAIL reset_pulses: done=%b err=%b abort=%b want 000", if0.DONE, if0.ERR, if0.ABORT); end
        tests++; if (if0.Q !== 8'h00) begin fails++; $display("FAIL reset_q: got %h want 00", if0.Q); end
        tests++; if (if0.ERR_CNT !== 8'd0 || if2.ERR_CNT !== 2'd0) begin
            fails++; $display("FAIL reset_errcnt: got %0d/%0d want 0/0", if0.ERR_CNT, if2.ERR_CNT); end
    endtask

    task automatic test_even_good();
        reset_dut();
        send_frame(8'hA5, 1'b0, 0, 1'b0);
        tests++; if (if0.BUSY !== 1'b1 || if0.DONE !== 1'b0) begin
            fails++; $display("FAIL good_busy_mid: busy=%b done=%b want 1 0", if0.BUSY, if0.DONE); end
        idle_step();
        tests++; if (if0.DONE !== 1'b1) begin fails++; $display("FAIL good_done: got %b want 1", if0.DONE); end
        tests++; if (if0.ERR !== 1'b0) begin fails++; $display("FAIL good_err: got %b want 0", if0.ERR); end
        tests++; if (if0.Q !== 8'hA5) begin fails++; $display("FAIL good_q: got %h want a5", if0.Q); end
        tests++; if (if0.ERR_CNT !== 8'd0 || if0.BUSY !== 1'b0) begin
            fails++; $display("FAIL good_cnt_busy: cnt=%0d busy=%b want 0 0", if0.ERR_CNT, if0.BUSY); end
        idle_step();
        tests++; if (if0.DONE !== 1'b0) begin fails++; $display("FAIL good_done_pulse: got %b want 0", if0.DONE); end
    endtask

    task automatic test_even_bad();
        for (int k = 1; k <= 3; k++) begin
            send_frame(8'hA5, 1'b1, 0, 1'b0);
            idle_step();
            tests++; if (if0.DONE !== 1'b1 || if0.ERR !== 1'b1) begin
                fails++; $display("FAIL bad_done_err[%0d]: done=%b err=%b want 1 1", k, if0.DONE, if0.ERR); end
            tests++; if (if0.ERR_CNT !== 8'(k)) begin
                fails++; $display("FAIL bad_errcnt[%0d]: got %0d want %0d", k, if0.ERR_CNT, k); end
        end
        idle_step();
        tests++; if (if0.ERR !== 1'b0) begin fails++; $display("FAIL bad_err_only_with_done: got %b want 0", if0.ERR); end
    endtask

    task automatic test_odd();
        send_frame(8'h01, 1'b0, 0, 1'b0);
        idle_step();
        tests++; if (if1.DONE !== 1'b1 || if1.ERR !== 1'b0 || if1.Q !== 8'h01) begin
            fails++; $display("FAIL odd_p0: done=%b err=%b q=%h want 1 0 01", if1.DONE, if1.ERR, if1.Q); end
        send_frame(8'h01, 1'b1, 0, 1'b0);
        idle_step();
        tests++; if (if1.DONE !== 1'b1 || if1.ERR !== 1'b1) begin
            fails++; $display("FAIL odd_p1: done=%b err=%b want 1 1", if1.DONE, if1.ERR); end
    endtask

    task automatic test_gaps();
        reset_dut();
        done_cnt = 0; abort_cnt = 0;
        send_frame(8'h3C, 1'b0, 2, 1'b0);
        tests++; if (done_cnt != 0) begin fails++; $display("FAIL gaps_early_done: got %0d want 0", done_cnt); end
        idle_step();
        tests++; if (if0.DONE !== 1'b1) begin fails++; $display("FAIL gaps_done: got %b want 1", if0.DONE); end
        tests++; if (if0.Q !== 8'h3C || if0.ERR !== 1'b0) begin
            fails++; $display("FAIL gaps_q_err: q=%h err=%b want 3c 0", if0.Q, if0.ERR); end
        repeat (3) idle_step();
        tests++; if (done_cnt != 1 || abort_cnt != 0) begin
            fails++; $display("FAIL gaps_pulses: done=%0d abort=%0d want 1 0", done_cnt, abort_cnt); end
    endtask

    task automatic test_restart();
        logic [7:0] w;
        reset_dut();
        send_frame(8'h11, 1'b0, 0, 1'b0);
        idle_step();
        done_cnt = 0; abort_cnt = 0;
        step(1'b1, 1'b1, 1'b1);
        for (int i = 1; i < 4; i++) step(1'b1, 1'b0, 1'b1);
        w = 8'h5A;
        step(1'b1, 1'b1, w[0]);
        step(1'b1, 1'b0, w[1]);
        tests++; if (if0.ABORT !== 1'b1 || if0.DONE !== 1'b0) begin
            fails++; $display("FAIL restart_abort: abort=%b done=%b want 1 0", if0.ABORT, if0.DONE); end
        tests++; if (if0.Q !== 8'h11 || if0.BUSY !== 1'b1) begin
            fails++; $display("FAIL restart_q_hold: q=%h busy=%b want 11 1", if0.Q, if0.BUSY); end
        for (int i = 2; i < 8; i++) step(1'b1, 1'b0, w[i]);
        step(1'b1, 1'b0, 1'b0);
        idle_step();
        tests++; if (if0.DONE !== 1'b1 || if0.Q !== 8'h5A || if0.ERR !== 1'b0) begin
            fails++; $display("FAIL restart_next: done=%b q=%h err=%b want 1 5a 0", if0.DONE, if0.Q, if0.ERR); end
        tests++; if (abort_cnt != 1 || done_cnt != 1) begin
            fails++; $display("FAIL restart_pulses: abort=%0d done=%0d want 1 1", abort_cnt, done_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] w;
        reset_dut();
        send_frame(8'h0F, 1'b0, 0, 1'b0);
        w = 8'hF0;
        step(1'b1, 1'b1, w[0]);
        tests++; if (if0.DONE !== 1'b1 || if0.Q !== 8'h0F) begin
            fails++; $display("FAIL b2b_first: done=%b q=%h want 1 0f", if0.DONE, if0.Q); end
        for (int i = 1; i < 8; i++) step(1'b1, 1'b0, w[i]);
        step(1'b1, 1'b0, 1'b0);
        idle_step();
        tests++; if (if0.DONE !== 1'b1 || if0.Q !== 8'hF0 || if0.ERR !== 1'b0) begin
            fails++; $display("FAIL b2b_second: done=%b q=%h err=%b want 1 f0 0", if0.DONE, if0.Q, if0.ERR); end
        tests++; if (if0.ERR_CNT !== 8'd0) begin fails++; $display("FAIL b2b_errcnt: got %0d want 0", if0.ERR_CNT); end
    endtask

    task automatic test_saturate();
        int exp_cnt [5] = '{1, 2, 3, 3, 3};
        reset_dut();
        for (int k = 0; k < 5; k++) begin
            send_frame(8'hA5, 1'b1, 0, 1'b0);
            idle_step();
            tests++; if (if2.ERR_CNT !== 2'(exp_cnt[k])) begin
                fails++; $display("FAIL sat_cnt[%0d]: got %0d want %0d", k, if2.ERR_CNT, exp_cnt[k]); end
        end
        send_frame(8'hA5, 1'b1, 0, 1'b1);
        idle_step();
        tests++; if (if2.DONE !== 1'b1 || if2.ERR !== 1'b1) begin
            fails++; $display("FAIL sat_clr_done: done=%b err=%b want 1 1", if2.DONE, if2.ERR); end
        tests++; if (if2.ERR_CNT !== 2'd0 || if0.ERR_CNT !== 8'd0) begin
            fails++; $display("FAIL sat_clr_wins: got %0d/%0d want 0/0", if2.ERR_CNT, if0.ERR_CNT); end
    endtask

    task automatic test_mid_reset();
        reset_dut();
        send_frame(8'hA5, 1'b1, 0, 1'b0);
        idle_step();
        done_cnt = 0; abort_cnt = 0;
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        @(negedge CLK);
        sample_mon();
        RST = 1'b1; en = 1'b1; start = 1'b0; d = 1'b1;
        @(negedge CLK);
        sample_mon();
        tests++; if (if0.BUSY !== 1'b0 || if0.Q !== 8'h00 || if0.ERR_CNT !== 8'd0) begin
            fails++; $display("FAIL midrst_state: busy=%b q=%h cnt=%0d want 0 00 0", if0.BUSY, if0.Q, if0.ERR_CNT); end
        RST = 1'b0; en = 1'b0;
        repeat (3) idle_step();
        tests++; if (done_cnt != 0 || abort_cnt != 0) begin
            fails++; $display("FAIL midrst_pulses: done=%0d abort=%0d want 0 0", done_cnt, abort_cnt); end
        send_frame(8'h96, 1'b0, 0, 1'b0);
        idle_step();
        tests++; if (if0.DONE !== 1'b1 || if0.Q !== 8'h96 || if0.ERR !== 1'b0) begin
            fails++; $display("FAIL midrst_next: done=%b q=%h err=%b want 1 96 0", if0.DONE, if0.Q, if0.ERR); end
    endtask

    initial begin
        tests = 0; fails = 0; done_cnt = 0; abort_cnt = 0;
        RST = 1'b1; en = 1'b0; start = 1'b0; d = 1'b0; clr = 1'b0;
        test_reset();
        test_even_good();
        test_even_bad();
        test_odd();
        test_gaps();
        test_restart();
        test_back_to_back();
        test_saturate();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
